// File: rtl/fmap_stream_buf_if.sv
// Stream bundle between a conv layer, the feature-map frame buffer and the next layer.
// The master side writes pixels and requests replays; the buffer (slave) drives the replay stream and status.
interface fmap_stream_buf_if #(
  parameter int N       = 16,
  parameter int CHANNEL = 32
);
  logic                   wr_vld;
  logic [CHANNEL*N-1:0]   wr_din;
  logic                   rd_start;
  logic                   dout_vld;
  logic [CHANNEL*N-1:0]   dout;
  logic                   dout_last;
  logic                   full;
  logic                   busy;
  logic                   err_ovf;

  modport master (
    output wr_vld, wr_din, rd_start,
    input  dout_vld, dout, dout_last, full, busy, err_ovf
  );

  modport slave (
    input  wr_vld, wr_din, rd_start,
    output dout_vld, dout, dout_last, full, busy, err_ovf
  );
endinterface

// File: rtl/fmap_stream_buf.sv
// Single-frame feature-map buffer: captures SIZE*SIZE pixels from one layer and
// replays them in write order as a gap-free burst to the next layer.
module fmap_stream_buf #(
  parameter int N       = 16,
  parameter int CHANNEL = 32,
  parameter int SIZE    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  fmap_stream_buf_if.slave bus
);
  localparam int TOTAL = SIZE * SIZE;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int W     = CHANNEL * N;
  localparam logic [CW-1:0] LAST_ADDR = CW'(TOTAL - 1);
  localparam logic [CW-1:0] TOTAL_CNT = CW'(TOTAL);

  typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} state_t;

  state_t        state;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [W-1:0]  mem [TOTAL];
  logic [W-1:0]  mem_q;
  logic          rd_vld_q;
  logic          rd_last_q;
  logic          frame_done;
  logic          wr_accept;
  logic          rd_issue;

  // The edge that retires the last replay beat already belongs to the next frame.
  assign frame_done = (state == READ) && bus.dout_last;
  assign wr_accept  = bus.wr_vld && ((state == EMPTY) || (state == FILL) || frame_done);
  assign rd_issue   = (state == READ) && (rd_cnt != TOTAL_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      bus.full    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.err_ovf <= 1'b0;
    end else begin
      if (bus.wr_vld && !wr_accept) begin
        bus.err_ovf <= 1'b1;
      end
      if (rd_issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (wr_accept) begin
        bus.busy <= 1'b0;
        if (wr_cnt == LAST_ADDR) begin
          state    <= FULL;
          wr_cnt   <= '0;
          bus.full <= 1'b1;
        end else begin
          state    <= FILL;
          wr_cnt   <= wr_cnt + 1'b1;
          bus.full <= 1'b0;
        end
      end else if ((state == FULL) && bus.rd_start) begin
        state    <= READ;
        rd_cnt   <= '0;
        bus.full <= 1'b0;
        bus.busy <= 1'b1;
      end else if (frame_done) begin
        state    <= EMPTY;
        bus.busy <= 1'b0;
      end
    end
  end

  // Storage is deliberately never cleared; a stale frame cannot be replayed without refilling.
  always_ff @(posedge clk) begin
    if (wr_accept && rst_n) begin
      mem[wr_cnt[AW-1:0]] <= bus.wr_din;
    end
    if (rd_issue) begin
      mem_q <= mem[rd_cnt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      bus.dout_vld  <= 1'b0;
      bus.dout_last <= 1'b0;
      bus.dout      <= '0;
    end else begin
      rd_vld_q      <= rd_issue;
      rd_last_q     <= rd_issue && (rd_cnt == LAST_ADDR);
      bus.dout_vld  <= rd_vld_q;
      bus.dout_last <= rd_last_q;
      if (rd_vld_q) begin
        bus.dout <= mem_q;
      end
    end
  end
endmodule

// File: tb/tb_fmap_stream_buf.sv
// Directed bench for fmap_stream_buf: fill/replay, gaps, overflow, early start,
// mid-replay reset and back-to-back frames, with hand-derived pixel values.
module tb_fmap_stream_buf;
  localparam int N       = 16;
  localparam int CHANNEL = 2;
  localparam int SIZE    = 6;
  localparam int TOTAL   = SIZE * SIZE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fmap_stream_buf_if #(.N(N), .CHANNEL(CHANNEL)) bus ();

  fmap_stream_buf #(.N(N), .CHANNEL(CHANNEL), .SIZE(SIZE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pixel k carries channel1 = k+100, channel0 = k.
  function automatic logic [31:0] pix(input int k);
    logic [15:0] c1;
    logic [15:0] c0;
    c1 = 16'(k + 100);
    c0 = 16'(k);
    return {c1, c0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n        = 1'b0;
    bus.wr_vld   = 1'b0;
    bus.wr_din   = '0;
    bus.rd_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic applyPixel(input int idx, input int base, input int gap);
    bus.wr_vld = 1'b1;
    bus.wr_din = pix(base + idx);
    tick();
    bus.wr_vld = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic applyFrame(input int base, input int gap);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == TOTAL - 1) checkOutput("full_before_last", {31'd0, bus.full}, 32'd0);
      applyPixel(i, base, gap);
    end
    checkOutput("full_after_last", {31'd0, bus.full}, 32'd1);
    checkOutput("busy_after_fill", {31'd0, bus.busy}, 32'd0);
  endtask

  // mode 1: stray write at beat 5; mode 2: write coincident with rd_start.
  task automatic checkReplay(input int base, input int mode);
    if (mode == 2) begin
      bus.wr_vld = 1'b1;
      bus.wr_din = 32'hDEADBEEF;
    end
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    bus.wr_vld   = 1'b0;
    checkOutput("busy_at_start", {31'd0, bus.busy}, 32'd1);
    checkOutput("full_at_start", {31'd0, bus.full}, 32'd0);
    checkOutput("vld_edge_k", {31'd0, bus.dout_vld}, 32'd0);
    tick();
    checkOutput("vld_edge_k1", {31'd0, bus.dout_vld}, 32'd0);
    for (int b = 0; b < TOTAL; b++) begin
      if (mode == 1 && b == 5) begin
        bus.wr_vld = 1'b1;
        bus.wr_din = 32'hDEADBEEF;
      end
      tick();
      bus.wr_vld = 1'b0;
      checkOutput($sformatf("vld[%0d]", b), {31'd0, bus.dout_vld}, 32'd1);
      checkOutput($sformatf("dout[%0d]", b), bus.dout, pix(base + b));
      checkOutput($sformatf("last[%0d]", b), {31'd0, bus.dout_last}, (b == TOTAL - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic checkEnd();
    tick();
    checkOutput("end_vld", {31'd0, bus.dout_vld}, 32'd0);
    checkOutput("end_last", {31'd0, bus.dout_last}, 32'd0);
    checkOutput("end_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("end_full", {31'd0, bus.full}, 32'd0);
  endtask

  initial begin
    bus.wr_vld   = 1'b0;
    bus.wr_din   = '0;
    bus.rd_start = 1'b0;

    applyReset();
    checkOutput("rst_vld", {31'd0, bus.dout_vld}, 32'd0);
    checkOutput("rst_full", {31'd0, bus.full}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.err_ovf}, 32'd0);
    checkOutput("rst_dout", bus.dout, 32'd0);

    $display("[TB] back-to-back fill and replay");
    applyFrame(0, 0);
    checkReplay(0, 0);
    checkEnd();
    checkOutput("err_clean", {31'd0, bus.err_ovf}, 32'd0);

    $display("[TB] gapped fill");
    applyFrame(0, 2);
    checkReplay(0, 0);
    checkEnd();

    $display("[TB] overflow on 37th write");
    applyFrame(200, 0);
    checkOutput("err_before_37", {31'd0, bus.err_ovf}, 32'd0);
    applyPixel(0, 999, 0);
    checkOutput("err_after_37", {31'd0, bus.err_ovf}, 32'd1);
    checkOutput("full_after_37", {31'd0, bus.full}, 32'd1);
    checkReplay(200, 0);
    checkEnd();

    $display("[TB] write during replay");
    applyReset();
    checkOutput("err_cleared", {31'd0, bus.err_ovf}, 32'd0);
    applyFrame(300, 0);
    checkReplay(300, 1);
    checkEnd();
    checkOutput("err_read_write", {31'd0, bus.err_ovf}, 32'd1);

    $display("[TB] write coincident with start");
    applyReset();
    applyFrame(350, 0);
    checkReplay(350, 2);
    checkEnd();
    checkOutput("err_start_write", {31'd0, bus.err_ovf}, 32'd1);

    $display("[TB] early start ignored");
    applyReset();
    for (int i = 0; i < 20; i++) applyPixel(i, 400, 0);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    checkOutput("early_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    tick();
    checkOutput("early_vld", {31'd0, bus.dout_vld}, 32'd0);
    for (int i = 20; i < TOTAL; i++) applyPixel(i, 400, 0);
    checkOutput("early_full", {31'd0, bus.full}, 32'd1);
    checkReplay(400, 0);
    checkEnd();

    $display("[TB] reset mid-replay");
    applyFrame(500, 0);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    tick();
    repeat (10) tick();
    checkOutput("mid_dout9", bus.dout, pix(509));
    rst_n      = 1'b0;
    bus.wr_vld = 1'b1;
    bus.wr_din = pix(999);
    tick();
    rst_n      = 1'b1;
    bus.wr_vld = 1'b0;
    checkOutput("mid_rst_vld", {31'd0, bus.dout_vld}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("mid_rst_full", {31'd0, bus.full}, 32'd0);
    checkOutput("mid_rst_last", {31'd0, bus.dout_last}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, bus.err_ovf}, 32'd0);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    checkOutput("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    tick();
    checkOutput("post_rst_vld", {31'd0, bus.dout_vld}, 32'd0);
    applyFrame(600, 0);
    checkReplay(600, 0);

    $display("[TB] frame B chained onto frame A");
    applyPixel(0, 700, 0);
    checkOutput("chain_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("chain_vld", {31'd0, bus.dout_vld}, 32'd0);
    checkOutput("chain_full", {31'd0, bus.full}, 32'd0);
    checkOutput("chain_err", {31'd0, bus.err_ovf}, 32'd0);
    for (int i = 1; i < TOTAL; i++) begin
      if (i == TOTAL - 1) checkOutput("chain_full_pre", {31'd0, bus.full}, 32'd0);
      applyPixel(i, 700, 0);
    end
    checkOutput("chain_full_post", {31'd0, bus.full}, 32'd1);
    checkReplay(700, 0);
    checkEnd();
    checkOutput("chain_err_end", {31'd0, bus.err_ovf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fmap_stream_buf.md
FMAP_STREAM_BUF -- requirements
Module: fmap_stream_buf

Interface
REQ-001 SHALL have parameter N, default 16, bit width of one channel sample.
REQ-002 SHALL have parameter CHANNEL, default 32, number of channels packed per pixel word.
REQ-003 SHALL have parameter SIZE, default 6, feature-map side length; one frame is SIZE*SIZE pixels.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port wr_vld, input, 1, write pixel valid (driven by a conv layer's output-valid).
REQ-007 SHALL have port wr_din, input, CHANNEL*N, write pixel; channel c occupies bits [(c+1)*N-1 : c*N].
REQ-008 SHALL have port rd_start, input, 1, single-cycle request to replay the stored frame.
REQ-009 SHALL have port dout_vld, output, 1, replay pixel valid (drives the next layer's input-valid).
REQ-010 SHALL have port dout, output, CHANNEL*N, replay pixel, same packing as wr_din.
REQ-011 SHALL have port dout_last, output, 1, high with the final replay pixel only.
REQ-012 SHALL have port full, output, 1, complete frame stored and not yet replayed.
REQ-013 SHALL have port busy, output, 1, replay in progress.
REQ-014 SHALL have port err_ovf, output, 1, sticky flag: a write was dropped.

Function
REQ-015 SHALL implement states EMPTY, FILL, FULL, READ; full=1 only in FULL, busy=1 only in READ.
REQ-016 SHALL store wr_din at address wr_cnt on each rising edge with wr_vld=1 in EMPTY or FILL, then increment wr_cnt; wr_cnt is ceil(log2(SIZE*SIZE+1)) bits.
REQ-017 SHALL go EMPTY->FILL on the first accepted write, and to FULL on the edge storing pixel SIZE*SIZE-1 (SIZE=1: EMPTY->FULL directly); wr_cnt returns to 0.
REQ-018 SHALL tolerate gaps (wr_vld low) of any length in FILL without losing or reordering pixels.
REQ-019 SHALL drop wr_vld beats arriving in FULL or READ and set err_ovf on that edge; the buffer contents are not altered.
REQ-020 SHALL ignore rd_start in EMPTY, FILL and READ.
REQ-021 SHALL, on rd_start=1 sampled in FULL at edge k, enter READ at edge k and drive dout_vld=1 from edge k+2 for exactly SIZE*SIZE consecutive cycles with no bubbles.
REQ-022 SHALL present pixels on dout in write order, address 0 first; dout is registered and meaningful only while dout_vld=1.
REQ-023 SHALL assert dout_last in the same cycle as the SIZE*SIZE-th dout_vld beat, and zero otherwise.
REQ-024 SHALL return to EMPTY on the edge that removes the last dout_vld beat; busy falls at that same edge; a write on that edge or later is accepted as pixel 0 of a new frame.
REQ-025 SHALL, on simultaneous rd_start and wr_vld in FULL, take the start and drop the write (err_ovf=1).
REQ-026 SHALL hold storage as SIZE*SIZE words of CHANNEL*N bits with one write and one read port, one-cycle synchronous read.

Reset
REQ-027 SHALL, on a rising edge with rst_n=0, enter EMPTY, clear wr_cnt and read counter, and drive dout_vld=0, dout_last=0, full=0, busy=0, err_ovf=0, dout=0, from any state including mid-FILL or mid-READ.
REQ-028 SHALL NOT clear storage contents on reset; they are stale and never replayed without a new full frame.
REQ-029 SHALL ignore wr_vld and rd_start on any edge where rst_n=0.

Verification
REQ-030 Fill/replay, SIZE=6, CHANNEL=2, N=16: write 36 pixels {c1=i+100, c0=i} back-to-back, pulse rd_start -> full=1 after 36th write; dout_vld high 36 cycles starting 2 edges after start, pixel i = {i+100, i}, dout_last on beat 36, then full=0, busy=0.
REQ-031 Gapped write: 36 pixels with wr_vld toggling 1,0,0 -> identical replay sequence, full rises only at 36th accepted beat.
REQ-032 Overflow: 37 writes then rd_start -> err_ovf=1 after 37th, replay shows pixels 0..35 unchanged; write during READ also sets err_ovf.
REQ-033 Early start: rd_start after 20 writes -> ignored, dout_vld stays 0; 16 more writes then rd_start -> normal 36-beat replay.
REQ-034 Reset mid-READ at beat 10 -> next edge dout_vld=0, busy=0, full=0; rd_start afterwards ignored until 36 new writes.
REQ-035 Back-to-back frames: write frame B starting the cycle after A's dout_last -> B stored fully, replay yields B values only.
